ppl_elastic_buf: RTL and testbench

Parametrised elastic pipeline buffer, the successor to the fixed ID/EX pipeline register with stall and flush. It holds up to DEPTH in-flight stage payloads under a valid/ready handshake instead of a global stall. Each payload splits into a control field, zeroed on flush and when invalid, and a data field that is never flushed. It sits between decode and execute, and any other stage boundary, so decode can run ahead while execute is busy, e.g. during a multi-cycle multiply.

---
 rtl/ppl_elastic_buf.sv | 134 +++++++++++++
 tb/tb_ppl_elastic_buf.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppl_elastic_buf.sv
// ppl_elastic_buf -- parametrised elastic pipeline buffer.
//
// Holds up to DEPTH stage payloads between two pipeline stages under a
// valid/ready handshake, replacing a stall-driven pipeline register. Each
// payload is a control field (forced to zero on the output whenever the head
// is invalid, and discarded by flush) plus a data field that flush never
// clears.
//
// Parameters:
//   CTRL_W  control field width
//   DATA_W  data field width
//   DEPTH   number of entries (>= 1, any value, not only powers of two)
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst_n        synchronous active-low reset
//   flush        drop every held entry and any same-cycle input
//   in_valid     upstream payload valid
//   in_ready     buffer can accept (count < DEPTH), derived from state only
//   in_ctrl      upstream control field
//   in_data      upstream data field
//   out_valid    head entry valid (count != 0)
//   out_ready    downstream accepts head
//   out_ctrl     head control field, zero when out_valid = 0
//   out_data     head data field, last value written to the head slot
//   stall_cnt    cycles with in_valid & !in_ready   (PPL_ELASTIC_BUF_PERF_EN only)
//   bubble_cnt   cycles with out_ready & !out_valid (PPL_ELASTIC_BUF_PERF_EN only)
//   count        occupied entries
//
// Build option: define PPL_ELASTIC_BUF_PERF_EN to add the two performance
// counters. They are cleared only by reset, ignore flush and wrap at 2^32.

module ppl_elastic_buf #(
  parameter int CTRL_W = 24,
  parameter int DATA_W = 128,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [DATA_W-1:0]          out_data,
`ifdef PPL_ELASTIC_BUF_PERF_EN
  output logic [31:0]                stall_cnt,
  output logic [31:0]                bubble_cnt,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  // A single-entry buffer still needs a 1-bit pointer to stay legal.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [CTRL_W-1:0] ctrl_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Both handshake flags depend on registered count only, so there is no
  // combinational path from out_ready to in_ready or from in_* to out_*.
  assign in_ready  = (count < FULL_CNT);
  assign out_valid = (count != '0);

  // Flush outranks both sides of the handshake.
  assign push = in_valid  & in_ready  & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is reset on purpose so out_data reads zero after
  // reset; flush leaves the stored words untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else if (push) begin
      ctrl_mem[wr_ptr] <= in_ctrl;
      data_mem[wr_ptr] <= in_data;
    end
  end

  assign out_ctrl = out_valid ? ctrl_mem[rd_ptr] : '0;
  assign out_data = data_mem[rd_ptr];

`ifdef PPL_ELASTIC_BUF_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (in_valid & ~in_ready)   stall_cnt  <= stall_cnt + 32'd1;
      if (out_ready & ~out_valid) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ppl_elastic_buf.sv
// tb_ppl_elastic_buf -- self-checking bench for ppl_elastic_buf.
//
// Two instances (DEPTH=2 and DEPTH=3) are each compared, cycle by cycle,
// against a queue model of an elastic buffer: push appends, pop removes the
// front, flush empties the queue. With PPL_ELASTIC_BUF_PERF_EN defined a third
// DEPTH=1 instance exercises the performance counters.

module tb_ppl_elastic_buf;

  typedef struct packed {
    logic [7:0]  c;
    logic [15:0] d;
  } pay_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  // Index 0 is the DEPTH=2 instance, index 1 the DEPTH=3 instance.
  logic        f    [2];
  logic        iv   [2];
  logic        ordy [2];
  logic [7:0]  ic   [2];
  logic [15:0] id   [2];
  logic        ir   [2];
  logic        ov   [2];
  logic [7:0]  oc   [2];
  logic [15:0] od   [2];
  logic [1:0]  cnt  [2];

  pay_t       q [2][$];
  logic [7:0] popped [$];
  bit         last_push;
  int         pass_cnt  = 0;
  int         fail_cnt  = 0;
  int         total_cnt = 0;

  always #5 clk = ~clk;

`ifdef PPL_ELASTIC_BUF_PERF_EN
  logic [31:0] sc [2];
  logic [31:0] bc [2];
  logic        f1, iv1, ir1, ov1, or1;
  logic [7:0]  ic1, oc1;
  logic [15:0] id1, od1;
  logic [0:0]  cnt1;
  logic [31:0] sc1, bc1;

  ppl_elastic_buf #(.CTRL_W(8), .DATA_W(16), .DEPTH(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .flush(f1), .in_valid(iv1), .in_ready(ir1),
    .in_ctrl(ic1), .in_data(id1), .out_valid(ov1), .out_ready(or1),
    .out_ctrl(oc1), .out_data(od1), .stall_cnt(sc1), .bubble_cnt(bc1),
    .count(cnt1)
  );
`endif

  ppl_elastic_buf #(.CTRL_W(8), .DATA_W(16), .DEPTH(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .flush(f[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_ctrl(ic[0]), .in_data(id[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_ctrl(oc[0]), .out_data(od[0]),
`ifdef PPL_ELASTIC_BUF_PERF_EN
    .stall_cnt(sc[0]), .bubble_cnt(bc[0]),
`endif
    .count(cnt[0])
  );

  ppl_elastic_buf #(.CTRL_W(8), .DATA_W(16), .DEPTH(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .flush(f[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_ctrl(ic[1]), .in_data(id[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_ctrl(oc[1]), .out_data(od[1]),
`ifdef PPL_ELASTIC_BUF_PERF_EN
    .stall_cnt(sc[1]), .bubble_cnt(bc[1]),
`endif
    .count(cnt[1])
  );

  function automatic int depth_of(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input int k);
    int    n   = q[k].size();
    int    dep = depth_of(k);
    string nm  = $sformatf("d%0d", dep);
    check({nm, ".count"},     32'(cnt[k]), 32'(n));
    check({nm, ".in_ready"},  32'(ir[k]),  32'(n < dep));
    check({nm, ".out_valid"}, 32'(ov[k]),  32'(n != 0));
    if (n != 0) begin
      check({nm, ".out_ctrl"}, 32'(oc[k]), 32'(q[k][0].c));
      check({nm, ".out_data"}, 32'(od[k]), 32'(q[k][0].d));
    end else begin
      check({nm, ".out_ctrl_zero"}, 32'(oc[k]), 32'd0);
    end
  endtask

  // One clock cycle on instance k; the other instance sits idle.
  task automatic step(input int k, input logic fl, input logic v,
                      input logic [7:0] c, input logic [15:0] d, input logic r);
    int n = q[k].size();
    bit push, pop;
    f[k] = fl; iv[k] = v; ic[k] = c; id[k] = d; ordy[k] = r;
    push = v && (n < depth_of(k)) && !fl;
    pop  = (n != 0) && r && !fl;
    if (pop) popped.push_back(oc[k]);
    @(posedge clk); #1;
    if (fl) q[k].delete();
    else begin
      if (pop)  void'(q[k].pop_front());
      if (push) q[k].push_back(pay_t'{c, d});
    end
    last_push = push;
    f[k] = 1'b0; iv[k] = 1'b0; ordy[k] = 1'b0;
    check_model(k);
  endtask

  initial begin
    int         accepted;
    bit         hold, pv, fl, r;
    logic [7:0] pc;
    logic [15:0] pd;

    for (int k = 0; k < 2; k++) begin
      f[k] = 1'b0; iv[k] = 1'b0; ordy[k] = 1'b0; ic[k] = '0; id[k] = '0;
    end
`ifdef PPL_ELASTIC_BUF_PERF_EN
    f1 = 1'b0; iv1 = 1'b0; or1 = 1'b0; ic1 = '0; id1 = '0;
`endif

    // Reset held for two cycles.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_model(0);
    check_model(1);
    check("d2.reset_out_data", 32'(od[0]), 32'd0);
    check("d3.reset_out_data", 32'(od[1]), 32'd0);
    rst_n = 1'b1;

    // Streaming through DEPTH=2 with out_ready held high.
    popped.delete();
    for (int i = 1; i <= 8; i++) begin
      step(0, 1'b0, 1'b1, 8'(i), 16'(i * 3), 1'b1);
      check("d2.stream_ctrl", 32'(oc[0]), 32'(i));
      check("d2.stream_count", 32'(cnt[0]), 32'd1);
    end
    step(0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
    check("d2.stream_pops", 32'(popped.size()), 32'd8);
    for (int i = 0; i < popped.size(); i++)
      check("d2.stream_order", 32'(popped[i]), 32'(i + 1));

    // Backpressure on DEPTH=3: A,B,C accepted, D held until in_ready returns.
    popped.delete();
    step(1, 1'b0, 1'b1, 8'hA1, 16'h0A01, 1'b0);
    step(1, 1'b0, 1'b1, 8'hA2, 16'h0A02, 1'b0);
    step(1, 1'b0, 1'b1, 8'hA3, 16'h0A03, 1'b0);
    step(1, 1'b0, 1'b1, 8'hA4, 16'h0A04, 1'b0);
    check("d3.full_in_ready", 32'(ir[1]), 32'd0);
    check("d3.d_held_while_full", 32'(last_push), 32'd0);
    step(1, 1'b0, 1'b1, 8'hA4, 16'h0A04, 1'b1);
    check("d3.d_held_on_release", 32'(last_push), 32'd0);
    step(1, 1'b0, 1'b1, 8'hA4, 16'h0A04, 1'b1);
    check("d3.d_accepted", 32'(last_push), 32'd1);
    repeat (3) step(1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
    check("d3.bp_pops", 32'(popped.size()), 32'd4);
    for (int i = 0; i < popped.size(); i++)
      check("d3.bp_order", 32'(popped[i]), 32'(8'hA1 + i));

    // Flush with a concurrent push on a full DEPTH=2 buffer.
    step(0, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0);
    step(0, 1'b0, 1'b1, 8'h11, 16'hAAAA, 1'b0);
    step(0, 1'b0, 1'b1, 8'h22, 16'hBBBB, 1'b0);
    step(0, 1'b1, 1'b1, 8'h5A, 16'h5A5A, 1'b1);
    check("d2.flush_data_kept", 32'(od[0]), 32'hAAAA);
    popped.delete();
    step(0, 1'b0, 1'b1, 8'h33, 16'h3333, 1'b1);
    step(0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
    step(0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
    check("d2.post_flush_pops", 32'(popped.size()), 32'd1);
    for (int i = 0; i < popped.size(); i++)
      check("d2.post_flush_ctrl", 32'(popped[i]), 32'h33);

    // Wrap on DEPTH=3 with out_ready gaps every other cycle.
    popped.delete();
    accepted = 0;
    for (int cyc = 0; cyc < 40 && accepted < 10; cyc++) begin
      step(1, 1'b0, 1'b1, 8'(8'h40 + accepted), 16'(accepted), (cyc % 2) == 0);
      if (last_push) accepted++;
    end
    check("d3.wrap_accepted", 32'(accepted), 32'd10);
    repeat (4) step(1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
    check("d3.wrap_pops", 32'(popped.size()), 32'd10);
    for (int i = 0; i < popped.size(); i++)
      check("d3.wrap_order", 32'(popped[i]), 32'(8'h40 + i));

    // Randomised traffic with occasional flushes; upstream holds until accepted.
    for (int k = 0; k < 2; k++) begin
      hold = 1'b0;
      pv   = 1'b0;
      pc   = '0;
      pd   = '0;
      for (int n = 0; n < 150; n++) begin
        fl = ($urandom_range(0, 15) == 0);
        if (!hold) begin
          pv = ($urandom_range(0, 3) != 0);
          pc = 8'($urandom);
          pd = 16'($urandom);
        end
        r = ($urandom_range(0, 2) != 0);
        step(k, fl, pv, pc, pd, r);
        hold = pv && !last_push && !fl;
      end
    end
    popped.delete();

    // Reset mid-operation overrides flush and handshakes.
    step(1, 1'b0, 1'b1, 8'h77, 16'h7777, 1'b0);
    step(1, 1'b0, 1'b1, 8'h78, 16'h7878, 1'b0);
    f[1] = 1'b1; iv[1] = 1'b1; ic[1] = 8'h79; id[1] = 16'h7979; ordy[1] = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    f[1] = 1'b0; iv[1] = 1'b0; ordy[1] = 1'b0;
    q[0].delete();
    q[1].delete();
    check_model(0);
    check_model(1);
    check("d2.midreset_out_data", 32'(od[0]), 32'd0);
    check("d3.midreset_out_data", 32'(od[1]), 32'd0);

`ifdef PPL_ELASTIC_BUF_PERF_EN
    // DEPTH=1: four stalled cycles while full, two bubbles while empty.
    iv1 = 1'b1; ic1 = 8'h99; id1 = 16'h9999;
    @(posedge clk); #1;
    check("d1.count_full", 32'(cnt1), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("d1.in_ready_full", 32'(ir1), 32'd0);
    iv1 = 1'b0; or1 = 1'b1;
    @(posedge clk); #1;
    check("d1.count_empty", 32'(cnt1), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    or1 = 1'b0;
    check("d1.stall_cnt", sc1, 32'd4);
    check("d1.bubble_cnt", bc1, 32'd2);
    f1 = 1'b1;
    @(posedge clk); #1;
    f1 = 1'b0;
    check("d1.stall_cnt_flush", sc1, 32'd4);
    check("d1.bubble_cnt_flush", bc1, 32'd2);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
